// File: rtl/stage2_pkg.sv
// Shared Stage 2 constants, types and the unpacker state encoding.
package stage2_pkg;

   localparam int unsigned WORD_SIZE  = 64;
   localparam int unsigned CACHE_LINE = 128;
   localparam int unsigned BUF_W      = 2 * WORD_SIZE;
   localparam int unsigned CNT_W      = 8;
   localparam int unsigned LEN_W      = 7;

   typedef logic [LEN_W-1:0] len_t;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } unpack_state_e;

   // Field lengths run 1..WORD_SIZE; zero and anything wider are rejected.
   function automatic logic len_legal(input len_t l);
      return (l != '0) && (l <= LEN_W'(WORD_SIZE));
   endfunction

endpackage

// File: rtl/bit_extract.sv
// Combinational datapath: masks the requested field, drops consumed bits and
// appends a new word just above the surviving fill.
module bit_extract
   import stage2_pkg::*;
(
   input  logic [BUF_W-1:0]     buf_i,
   input  logic [CNT_W-1:0]     fill_i,
   input  len_t                 len_i,
   input  logic                 consume_i,
   input  logic [WORD_SIZE-1:0] word_i,
   input  logic                 insert_i,
   output logic [WORD_SIZE-1:0] field_o,
   output logic [BUF_W-1:0]     buf_o,
   output logic [CNT_W-1:0]     fill_o
);

   logic [WORD_SIZE-1:0] mask;
   logic [BUF_W-1:0]     shifted;
   logic [BUF_W-1:0]     placed;
   logic [CNT_W-1:0]     offset;

   always_comb begin
      // Shift of WORD_SIZE-len yields a mask of len ones; len 0 gives none.
      mask    = {WORD_SIZE{1'b1}} >> (LEN_W'(WORD_SIZE) - len_i);
      field_o = buf_i[WORD_SIZE-1:0] & mask;
      shifted = consume_i ? (buf_i >> len_i) : buf_i;
      offset  = consume_i ? (fill_i - CNT_W'(len_i)) : fill_i;
      placed  = BUF_W'(word_i) << offset;
      buf_o   = insert_i ? (shifted | placed) : shifted;
      fill_o  = offset + (insert_i ? CNT_W'(WORD_SIZE) : '0);
   end

endmodule

// File: rtl/stream_unpacker.sv
// Unpacks LSB-first packed words into variable-length fields and flags every
// completed CACHE_LINE worth of consumed bits.
module stream_unpacker
   import stage2_pkg::*;
(
   input  logic                 clk,
   input  logic                 i_reset,
   input  logic                 i_flush,
   input  logic [WORD_SIZE-1:0] i_word,
   input  logic                 i_word_valid,
   output logic                 o_word_ready,
   input  len_t                 i_req_length,
   input  logic                 i_req_valid,
   output logic                 o_req_ready,
   output logic [WORD_SIZE-1:0] o_data,
   output logic                 o_data_valid,
   output logic                 o_line_end,
   output logic                 o_len_err
);

   unpack_state_e        state_q, state_d;
   logic [BUF_W-1:0]     buf_q, buf_d;
   logic [CNT_W-1:0]     fill_q, fill_d;
   logic [CNT_W-1:0]     line_cnt_q, line_cnt_d;
   logic [WORD_SIZE-1:0] data_q, data_d;
   logic                 data_valid_q, data_valid_d;
   logic                 line_end_q, line_end_d;
   logic                 len_err_q, len_err_d;

   logic                 clear;
   logic                 len_ok;
   logic                 fits;
   logic                 req_acc;
   logic                 word_acc;
   logic [CNT_W-1:0]     sum;
   logic [WORD_SIZE-1:0] ext_field;
   logic [BUF_W-1:0]     ext_buf;
   logic [CNT_W-1:0]     ext_fill;

   // Handshakes look only at registered fill; a same-cycle word never helps a request.
   assign clear        = i_reset | i_flush;
   assign len_ok       = len_legal(i_req_length);
   assign fits         = (state_q == FULL) || (fill_q >= CNT_W'(i_req_length));
   assign req_acc      = i_req_valid & len_ok & fits & ~clear;
   assign o_req_ready  = req_acc;
   assign o_word_ready = (fill_q <= CNT_W'(WORD_SIZE));
   assign word_acc     = i_word_valid & o_word_ready & ~clear;

   bit_extract u_extract (
      .buf_i     (buf_q),
      .fill_i    (fill_q),
      .len_i     (i_req_length),
      .consume_i (req_acc),
      .word_i    (i_word),
      .insert_i  (word_acc),
      .field_o   (ext_field),
      .buf_o     (ext_buf),
      .fill_o    (ext_fill)
   );

   always_comb begin
      buf_d        = ext_buf;
      fill_d       = ext_fill;
      line_cnt_d   = line_cnt_q;
      data_d       = data_q;
      data_valid_d = 1'b0;
      line_end_d   = 1'b0;
      len_err_d    = i_req_valid & ~len_ok & ~clear;
      sum          = line_cnt_q + CNT_W'(i_req_length);
      state_d      = state_q;

      if (req_acc) begin
         data_d       = ext_field;
         data_valid_d = 1'b1;
         // Overflow past the line boundary carries into the next line.
         if (sum >= CNT_W'(CACHE_LINE)) begin
            line_cnt_d = sum - CNT_W'(CACHE_LINE);
            line_end_d = 1'b1;
         end else begin
            line_cnt_d = sum;
         end
      end

      if (clear) begin
         buf_d      = '0;
         fill_d     = '0;
         line_cnt_d = '0;
      end

      if (fill_d == '0) begin
         state_d = EMPTY;
      end else if (fill_d < CNT_W'(WORD_SIZE)) begin
         state_d = PARTIAL;
      end else begin
         state_d = FULL;
      end
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q      <= EMPTY;
         buf_q        <= '0;
         fill_q       <= '0;
         line_cnt_q   <= '0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         line_end_q   <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         fill_q       <= fill_d;
         line_cnt_q   <= line_cnt_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         line_end_q   <= line_end_d;
         len_err_q    <= len_err_d;
      end
   end

   assign o_data       = data_q;
   assign o_data_valid = data_valid_q;
   assign o_line_end   = line_end_q;
   assign o_len_err    = len_err_q;

endmodule

// File: tb/tb_stream_unpacker.sv
// Scoreboard bench for stream_unpacker: a bit-queue reference model predicts
// handshakes and fields; a negedge monitor pops and compares every output pulse.
module tb_stream_unpacker;
   import stage2_pkg::*;

   logic        clk = 1'b0;
   logic        i_reset, i_flush, i_word_valid, i_req_valid;
   logic [63:0] i_word;
   logic [6:0]  i_req_length;
   logic        o_word_ready, o_req_ready, o_data_valid, o_line_end, o_len_err;
   logic [63:0] o_data;

   always #5 clk = ~clk;

   stream_unpacker dut (
      .clk          (clk),
      .i_reset      (i_reset),
      .i_flush      (i_flush),
      .i_word       (i_word),
      .i_word_valid (i_word_valid),
      .o_word_ready (o_word_ready),
      .i_req_length (i_req_length),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .o_line_end   (o_line_end),
      .o_len_err    (o_len_err)
   );

   typedef struct packed {
      logic [63:0] data;
      logic        le;
   } exp_t;

   exp_t exp_q[$];
   bit   mq[$];
   int   total;
   int   err_pend;
   int   le_cnt;
   int   n_cmp;
   int   n_fail;
   bit   mon_en;
   exp_t mon_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; model predicts readies, then updates on the edge.
   task automatic step(input logic rst, input logic fl, input logic wv, input logic [63:0] w,
                       input logic rv, input logic [6:0] l, output logic racc);
      logic        exp_rr, exp_wr, wacc;
      logic [63:0] f;
      int          old;
      @(negedge clk);
      i_reset = rst; i_flush = fl; i_word_valid = wv; i_word = w;
      i_req_valid = rv; i_req_length = l;
      #1;
      exp_wr = (mq.size() <= 64);
      exp_rr = rv && !rst && !fl && (l >= 7'd1) && (l <= 7'd64) && (mq.size() >= int'(l));
      check("word_ready", 64'(o_word_ready), 64'(exp_wr));
      check("req_ready", 64'(o_req_ready), 64'(exp_rr));
      wacc = wv && exp_wr && !rst && !fl;
      racc = exp_rr;
      @(posedge clk);
      if (rst || fl) begin
         mq.delete();
         total = 0;
      end else begin
         if (racc) begin
            f = '0;
            for (int i = 0; i < int'(l); i++) f[i] = mq.pop_front();
            old = total;
            total += int'(l);
            exp_q.push_back('{data: f, le: ((old / 128) != (total / 128))});
         end
         if (wacc) for (int i = 0; i < 64; i++) mq.push_back(w[i]);
         if (rv && ((l == 7'd0) || (l > 7'd64))) err_pend++;
      end
   endtask

   // Go idle at the next negedge so registered outputs of the last edge can be inspected.
   task automatic settle();
      @(negedge clk);
      i_reset = 1'b0; i_flush = 1'b0; i_word_valid = 1'b0; i_req_valid = 1'b0;
      i_req_length = '0;
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (o_data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL unexpected_data: got 0x%0h expected no output", o_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("data", o_data, mon_e.data);
               check("line_end", 64'(o_line_end), 64'(mon_e.le));
            end
         end else begin
            check("line_end_idle", 64'(o_line_end), 64'd0);
         end
         if (o_line_end === 1'b1) le_cnt++;
         if (o_len_err === 1'b1) begin
            n_cmp++;
            if (err_pend == 0) begin
               n_fail++;
               $display("FAIL unexpected_len_err: got 1 expected 0");
            end else begin
               err_pend--;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic        acc;
   logic [6:0]  seq [5];
   logic [63:0] wA, wB, wE;

   initial begin
      seq = '{7'd10, 7'd20, 7'd40, 7'd5, 7'd60};
      wA = 64'hA5A5_0F0F_1234_5678;
      wB = 64'hDEAD_BEEF_CAFE_F00D;
      wE = 64'h1122_3344_5566_7788;
      i_reset = 1'b1; i_flush = 1'b0; i_word_valid = 1'b0; i_word = '0;
      i_req_valid = 1'b0; i_req_length = '0;
      total = 0; err_pend = 0; le_cnt = 0; n_cmp = 0; n_fail = 0; mon_en = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_data", o_data, 64'd0);
      check("rst_valid", 64'(o_data_valid), 64'd0);
      check("rst_le", 64'(o_line_end), 64'd0);
      check("rst_err", 64'(o_len_err), 64'd0);
      check("rst_wready", 64'(o_word_ready), 64'd1);
      check("rst_rready", 64'(o_req_ready), 64'd0);
      i_reset = 1'b0;
      mon_en = 1'b1;

      // Single word, 10-bit field
      step(0, 0, 1, 64'h0000_0000_0000_03FF, 0, 0, acc);
      step(0, 0, 0, 0, 1, 7'd10, acc);
      settle();
      check("t1_data", o_data, 64'h3FF);
      check("t1_le", 64'(o_line_end), 64'd0);
      check("t1_fill", 64'(dut.fill_q), 64'd54);

      // 10/20/40/5/60 with stalls while words trickle in
      step(0, 1, 0, 0, 0, 0, acc);
      step(0, 0, 1, 64'h0123_4567_89AB_CDEF, 0, 0, acc);
      step(0, 0, 0, 0, 1, 7'd10, acc);
      step(0, 0, 0, 0, 1, 7'd20, acc);
      step(0, 0, 0, 0, 1, 7'd40, acc);
      check("t2_stall40", 64'(acc), 64'd0);
      step(0, 0, 1, 64'hFEDC_BA98_7654_3210, 1, 7'd40, acc);
      check("t2_stall40_word", 64'(acc), 64'd0);
      step(0, 0, 0, 0, 1, 7'd40, acc);
      step(0, 0, 0, 0, 1, 7'd5, acc);
      step(0, 0, 1, 64'h0F1E_2D3C_4B5A_6978, 1, 7'd60, acc);
      check("t2_stall60_word", 64'(acc), 64'd0);
      step(0, 0, 0, 0, 1, 7'd60, acc);
      settle();
      check("t2_le", 64'(o_line_end), 64'd1);
      check("t2_line_cnt", 64'(dut.line_cnt_q), 64'd7);

      // Same-cycle word and full-width request at fill 64
      step(0, 1, 0, 0, 0, 0, acc);
      step(0, 0, 1, wA, 0, 0, acc);
      step(0, 0, 1, wB, 1, 7'd64, acc);
      settle();
      check("t3_data", o_data, wA);
      check("t3_fill", 64'(dut.fill_q), 64'd64);
      step(0, 0, 0, 0, 1, 7'd64, acc);
      settle();
      check("t3_data2", o_data, wB);
      check("t3_le", 64'(o_line_end), 64'd1);

      // Illegal lengths leave state untouched
      step(0, 0, 1, wE, 0, 0, acc);
      step(0, 0, 0, 0, 1, 7'd0, acc);
      step(0, 0, 0, 0, 1, 7'd0, acc);
      step(0, 0, 0, 0, 1, 7'd65, acc);
      settle();
      check("t4_err", 64'(o_len_err), 64'd1);
      check("t4_fill", 64'(dut.fill_q), 64'd64);
      check("t4_line_cnt", 64'(dut.line_cnt_q), 64'd0);

      // Five passes of the sequence with a continuous word feed
      step(0, 1, 0, 0, 0, 0, acc);
      settle();
      le_cnt = 0;
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 5; k++) begin
            int budget;
            budget = 0;
            acc = 1'b0;
            while (!acc && budget < 10) begin
               step(0, 0, 1, {$urandom, $urandom}, 1, seq[k], acc);
               budget++;
            end
            if (!acc) begin
               n_cmp++; n_fail++;
               $display("FAIL t5_accept: got no accept expected accept for len %0d", seq[k]);
            end
         end
      end
      settle();
      check("t5_le_count", 64'(le_cnt), 64'd5);

      // Reset mid-stream with a request pending
      step(0, 1, 0, 0, 0, 0, acc);
      step(0, 0, 1, wA, 0, 0, acc);
      step(0, 0, 0, 0, 1, 7'd27, acc);
      settle();
      check("t6_fill37", 64'(dut.fill_q), 64'd37);
      step(1, 0, 0, 0, 1, 7'd8, acc);
      settle();
      check("t6_data", o_data, 64'd0);
      check("t6_valid", 64'(o_data_valid), 64'd0);
      check("t6_le", 64'(o_line_end), 64'd0);
      check("t6_err", 64'(o_len_err), 64'd0);
      check("t6_wready", 64'(o_word_ready), 64'd1);
      check("t6_rready", 64'(o_req_ready), 64'd0);
      check("t6_fill", 64'(dut.fill_q), 64'd0);
      step(0, 0, 1, wE, 0, 0, acc);
      step(0, 0, 0, 0, 1, 7'd8, acc);
      settle();
      check("t6_byte", o_data, 64'h88);

      repeat (3) settle();
      check("drain_data", 64'(exp_q.size()), 64'd0);
      check("drain_err", 64'(err_pend), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
